// File: rtl/noc_pkg.sv
// Shared NoC router types: flit type encoding, output port indices and the XY route function.
package noc_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  localparam int P_N       = 0;
  localparam int P_S       = 1;
  localparam int P_E       = 2;
  localparam int P_W       = 3;
  localparam int P_L       = 4;
  localparam int NUM_PORTS = 5;

  // Dimension-ordered routing: resolve X first, then Y, then eject locally.
  function automatic logic [NUM_PORTS-1:0] route_fn(input int unsigned dx,
                                                    input int unsigned dy,
                                                    input int unsigned lx,
                                                    input int unsigned ly);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (dx > lx)      r[P_E] = 1'b1;
    else if (dx < lx) r[P_W] = 1'b1;
    else if (dy > ly) r[P_N] = 1'b1;
    else if (dy < ly) r[P_S] = 1'b1;
    else              r[P_L] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with a registered occupancy count; full/empty derive from the count.
module flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] front_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign front_o = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guarantees stale entries are never presented as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/input_port_rc.sv
// Router input port: buffers flits, computes the XY route of each head and holds a one-hot
// request to the output arbiter until the packet's tail has been forwarded.
module input_port_rc
  import noc_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 4,
  parameter int          X_W     = 2,
  parameter int          Y_W     = 2,
  parameter int unsigned LOCAL_X = 0,
  parameter int unsigned LOCAL_Y = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic [DATA_W-1:0]    in_flit_i,
  output logic                 in_ready_o,
  output logic [NUM_PORTS-1:0] req_port_o,
  input  logic                 grant_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [DATA_W-1:0]    out_flit_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACTIVE
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] route_q, route_d;
  logic [NUM_PORTS-1:0] req_q, req_d;
  logic                 err_q, err_d;

  logic                 fifo_full, fifo_empty;
  logic [DATA_W-1:0]    front;
  flit_type_e           front_type;
  logic [X_W-1:0]       dest_x;
  logic [Y_W-1:0]       dest_y;
  logic                 front_is_head, front_is_tail;
  logic                 forward, stray_drop, pop;
  logic                 busy;

  flit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid_i),
    .pop_i   (pop),
    .data_i  (in_flit_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .front_o (front)
  );

  assign front_type    = flit_type_e'(front[DATA_W-1:DATA_W-2]);
  assign dest_x        = front[X_W-1:0];
  assign dest_y        = front[X_W+Y_W-1:X_W];
  assign front_is_head = (front_type == HEAD) || (front_type == SINGLE);
  assign front_is_tail = (front_type == TAIL) || (front_type == SINGLE);

  assign busy        = (state_q == S_REQ) || (state_q == S_ACTIVE);
  assign out_valid_o = grant_i & ~fifo_empty & busy;
  assign forward     = out_valid_o & out_ready_i;
  assign pop         = forward | stray_drop;

  assign in_ready_o  = ~fifo_full;
  assign out_flit_o  = front;
  assign req_port_o  = req_q;
  assign err_o       = err_q;

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    stray_drop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (front_is_head) begin
            route_d = route_fn(32'(dest_x), 32'(dest_y), LOCAL_X, LOCAL_Y);
            state_d = S_REQ;
          end else begin
            stray_drop = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (grant_i) state_d = (forward && front_is_tail) ? S_IDLE : S_ACTIVE;
      end
      S_ACTIVE: begin
        if (forward && front_is_tail) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = stray_drop;
    // The request appears one cycle after the route is latched and drops as the tail leaves.
    req_d = (busy && state_d != S_IDLE) ? route_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      route_q <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_input_port_rc.sv
// Self-checking bench for input_port_rc: directed scenarios plus a randomized packet stream
// checked against a queue-based reference of the buffered flits and an XY-route reference.
module tb_input_port_rc;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LX     = 1;
  localparam int LY     = 1;

  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;
  localparam logic [4:0] R_N = 5'b00001, R_S = 5'b00010, R_E = 5'b00100,
                         R_W = 5'b01000, R_L = 5'b10000;

  logic              clk, rst;
  logic              in_valid_i, grant_i, out_ready_i;
  logic [DATA_W-1:0] in_flit_i;
  logic              in_ready_o, out_valid_o, err_o;
  logic [4:0]        req_port_o;
  logic [DATA_W-1:0] out_flit_o;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] fifo_m[$];

  input_port_rc #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .X_W (2), .Y_W (2),
    .LOCAL_X(LX), .LOCAL_Y(LY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_flit_i  (in_flit_i),
    .in_ready_o (in_ready_o),
    .req_port_o (req_port_o),
    .grant_i    (grant_i),
    .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o),
    .out_flit_o (out_flit_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] ty, input int x, input int y,
                                           input logic [31:0] pay);
    logic [1:0] xb, yb;
    xb = 2'(x);
    yb = 2'(y);
    return {ty, pay[25:0], yb, xb};
  endfunction

  function automatic logic [4:0] ref_route(input logic [DATA_W-1:0] f);
    int dx, dy;
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (dx > LX) return R_E;
    if (dx < LX) return R_W;
    if (dy > LY) return R_N;
    if (dy < LY) return R_S;
    return R_L;
  endfunction

  // Caller is at a negedge with a non-full FIFO; the flit is taken at the next posedge.
  task automatic push(input logic [DATA_W-1:0] f);
    in_valid_i = 1'b1;
    in_flit_i  = f;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_req(input logic [4:0] exp, input string tag);
    for (int i = 0; i < 8 && req_port_o == 5'b0; i++) @(negedge clk);
    check(tag, 32'(req_port_o), 32'(exp));
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      grant_i     = (req_port_o != 5'b0);
      out_ready_i = 1'b1;
      #1;
      if (out_valid_o && out_ready_i) check(tag, out_flit_o, exp_q.pop_front());
      @(negedge clk);
    end
    grant_i     = 1'b0;
    out_ready_i = 1'b0;
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] f, pkt[4];
    logic [4:0]        cur_route;
    int                k, pulses;
    bit                granted;

    rst = 1'b1; in_valid_i = 1'b0; in_flit_i = '0; grant_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_req", 32'(req_port_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);

    // SINGLE east: request two edges after the push, forwarded in the grant cycle.
    f = mk(T_SINGLE, 3, 1, $urandom);
    push(f);
    @(negedge clk);
    check("t2_req_early", 32'(req_port_o), 32'd0);
    @(negedge clk);
    check("t2_req_e", 32'(req_port_o), 32'(R_E));
    grant_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check("t2_out_valid", 32'(out_valid_o), 32'd1);
    check("t2_out_flit", out_flit_o, f);
    @(negedge clk);
    grant_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("t2_req_drop", 32'(req_port_o), 32'd0);
    @(negedge clk);

    // Four-flit packet south with out_ready toggling.
    pkt[0] = mk(T_HEAD, 1, 0, $urandom);
    pkt[1] = mk(T_BODY, 0, 0, $urandom);
    pkt[2] = mk(T_BODY, 0, 0, $urandom);
    pkt[3] = mk(T_TAIL, 0, 0, $urandom);
    for (int i = 0; i < 4; i++) push(pkt[i]);
    wait_req(R_S, "t3_req_s");
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      grant_i = 1'b1;
      out_ready_i = (c % 2 == 0);
      #1;
      if (out_valid_o && out_ready_i) begin
        check("t3_flit", out_flit_o, pkt[k]);
        check("t3_req_held", 32'(req_port_o), 32'(R_S));
        k++;
      end
      @(negedge clk);
    end
    grant_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("t3_count", 32'(k), 32'd4);
    check("t3_req_drop", 32'(req_port_o), 32'd0);
    @(negedge clk);

    // Backpressure: fill to DEPTH, hold the fifth, then push+pop at count 3.
    pkt[0] = mk(T_HEAD, 2, 1, $urandom);
    for (int i = 0; i < 4; i++) push(i == 0 ? pkt[0] : mk(T_BODY, 0, 0, 32'(i)));
    #1;
    check("t4_full", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b1; in_flit_i = mk(T_TAIL, 0, 0, 32'h77);
    @(negedge clk);
    #1;
    check("t4_held", 32'(in_ready_o), 32'd0);
    grant_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check("t4_head_out", out_flit_o, pkt[0]);
    @(negedge clk);
    #1;
    check("t4_ready_at3", 32'(in_ready_o), 32'd1);
    check("t4_body1_out", out_flit_o, mk(T_BODY, 0, 0, 32'd1));
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("t4_count_stays3", 32'(in_ready_o), 32'd1);
    f = mk(T_SINGLE, 1, 1, 32'h99);
    push(f);
    #1;
    check("t4_full_again", 32'(in_ready_o), 32'd0);
    exp_q = '{mk(T_BODY, 0, 0, 32'd2), mk(T_BODY, 0, 0, 32'd3), mk(T_TAIL, 0, 0, 32'h77), f};
    drain("t4_drain");

    // Stray BODY in IDLE is dropped with a single error pulse and no request.
    push(mk(T_BODY, 3, 3, $urandom));
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (err_o) pulses++;
      check("t5_no_req", 32'(req_port_o), 32'd0);
      @(negedge clk);
    end
    check("t5_err_pulses", 32'(pulses), 32'd1);
    check("t5_in_ready", 32'(in_ready_o), 32'd1);

    // Local and west routes.
    f = mk(T_HEAD, 1, 1, $urandom);
    push(f); push(mk(T_TAIL, 0, 0, 32'h5));
    wait_req(R_L, "t6_req_l");
    exp_q = '{f, mk(T_TAIL, 0, 0, 32'h5)};
    drain("t6_drain_l");
    f = mk(T_HEAD, 0, 2, $urandom);
    push(f); push(mk(T_TAIL, 0, 0, 32'h6));
    wait_req(R_W, "t6_req_w");
    exp_q = '{f, mk(T_TAIL, 0, 0, 32'h6)};
    drain("t6_drain_w");

    // Randomized packet stream against the queue reference.
    for (int p = 0; p < 40; p++) begin
      int nb;
      if ($urandom_range(3) == 0) begin
        src_q.push_back(mk(T_SINGLE, $urandom_range(3), $urandom_range(3), $urandom));
      end else begin
        nb = $urandom_range(3);
        src_q.push_back(mk(T_HEAD, $urandom_range(3), $urandom_range(3), $urandom));
        for (int b = 0; b < nb; b++) src_q.push_back({T_BODY, 30'($urandom)});
        src_q.push_back({T_TAIL, 30'($urandom)});
      end
    end
    granted = 1'b0;
    cur_route = '0;
    for (int c = 0; c < 4000 && (src_q.size() > 0 || fifo_m.size() > 0); c++) begin
      in_valid_i = (src_q.size() > 0) && ($urandom_range(3) != 0);
      in_flit_i  = (src_q.size() > 0) ? src_q[0] : '0;
      out_ready_i = ($urandom_range(3) != 0);
      if (req_port_o == 5'b0) granted = 1'b0;
      else if (!granted && $urandom_range(1) == 1) granted = 1'b1;
      grant_i = granted;
      #1;
      check("rnd_in_ready", 32'(in_ready_o), 32'(fifo_m.size() < DEPTH));
      check("rnd_out_valid", 32'(out_valid_o), 32'(grant_i && fifo_m.size() > 0));
      check("rnd_err", 32'(err_o), 32'd0);
      if (out_valid_o) begin
        check("rnd_flit", out_flit_o, fifo_m[0]);
        if (fifo_m[0][31:30] == T_HEAD || fifo_m[0][31:30] == T_SINGLE)
          cur_route = ref_route(fifo_m[0]);
        check("rnd_req", 32'(req_port_o), 32'(cur_route));
      end
      if (out_valid_o && out_ready_i) void'(fifo_m.pop_front());
      if (in_valid_i && in_ready_o) fifo_m.push_back(src_q.pop_front());
      @(negedge clk);
    end
    in_valid_i = 1'b0; grant_i = 1'b0; out_ready_i = 1'b0;
    check("rnd_src_done", 32'(src_q.size()), 32'd0);
    check("rnd_fifo_done", 32'(fifo_m.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of a packet discards everything.
    push(mk(T_HEAD, 3, 3, $urandom)); push(mk(T_BODY, 0, 0, $urandom));
    wait_req(R_E, "t1_req_before");
    grant_i = 1'b1; out_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t1_req", 32'(req_port_o), 32'd0);
    check("t1_out_valid", 32'(out_valid_o), 32'd0);
    check("t1_in_ready", 32'(in_ready_o), 32'd1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("t1_empty_valid", 32'(out_valid_o), 32'd0);
      check("t1_empty_req", 32'(req_port_o), 32'd0);
    end
    grant_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
